// File: rtl/izh_pkg.sv
// Shared types and reset constants for the Izhikevich neuron scheduler.
// Values are 17-bit sign-magnitude: bit16 sign, 8 integer bits, 8 fraction bits.
package izh_pkg;

    localparam int unsigned FX_W = 17;

    typedef logic [FX_W-1:0] fx_t;

    localparam fx_t V_RST = 17'b1_0100_0001_0000_0000;
    localparam fx_t U_RST = 17'b1_0000_1101_0000_0000;
    localparam fx_t A_DEF = 17'b0_0000_0000_0000_0101;
    localparam fx_t B_DEF = 17'b0_0000_0000_0011_0011;
    localparam fx_t D_DEF = 17'b0_0000_1000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        CAPTURE,
        EMIT,
        DONE
    } izh_state_t;

    typedef struct packed {
        fx_t a;
        fx_t b;
        fx_t c;
        fx_t d;
        fx_t v;
        fx_t u;
    } neuron_t;

    function automatic neuron_t neuron_default();
        neuron_t n;
        n.a = A_DEF;
        n.b = B_DEF;
        n.c = V_RST;
        n.d = D_DEF;
        n.v = V_RST;
        n.u = U_RST;
        return n;
    endfunction

endpackage

// File: rtl/izh_state_bank.sv
// Per-neuron state (v, u) and parameter (a, b, c, d) storage with a single
// write port and an indexed combinational read; async reset restores defaults.
module izh_state_bank
    import izh_pkg::*;
#(
    parameter int unsigned N_NEURONS = 16,
    parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             we_param,
    input  logic [IDX_W-1:0] w_idx,
    input  neuron_t          w_data,
    input  logic [IDX_W-1:0] r_idx,
    output neuron_t          r_data
);

    neuron_t bank [N_NEURONS];

    // Writeback touches only v/u; a config write also replaces the parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                bank[n] <= neuron_default();
            end
        end else if (we) begin
            bank[w_idx].v <= w_data.v;
            bank[w_idx].u <= w_data.u;
            if (we_param) begin
                bank[w_idx].a <= w_data.a;
                bank[w_idx].b <= w_data.b;
                bank[w_idx].c <= w_data.c;
                bank[w_idx].d <= w_data.d;
            end
        end
    end

    assign r_data = bank[r_idx];

endmodule

// File: rtl/izh_scheduler.sv
// Time-multiplexes one shared Izhikevich datapath across N_NEURONS neurons.
// Optional IZH_SPIKE_COUNT_EN adds a per-timestep spike_count output.
module izh_scheduler
    import izh_pkg::*;
#(
    parameter int unsigned N_NEURONS = 16,
    parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [15:0]      timestep,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [FX_W-1:0]  cfg_a,
    input  logic [FX_W-1:0]  cfg_b,
    input  logic [FX_W-1:0]  cfg_c,
    input  logic [FX_W-1:0]  cfg_d,
    output logic             i_req,
    output logic [IDX_W-1:0] i_idx,
    input  logic             i_valid,
    input  logic [FX_W-1:0]  i_data,
    output logic [FX_W-1:0]  dp_a,
    output logic [FX_W-1:0]  dp_b,
    output logic [FX_W-1:0]  dp_c,
    output logic [FX_W-1:0]  dp_d,
    output logic [FX_W-1:0]  dp_v,
    output logic [FX_W-1:0]  dp_u,
    output logic [FX_W-1:0]  dp_i,
    input  logic [FX_W-1:0]  dp_v_prime,
    input  logic [FX_W-1:0]  dp_u_prime,
    input  logic             dp_fired,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    input  logic             spike_ready
`ifdef IZH_SPIKE_COUNT_EN
    ,
    output logic [IDX_W:0]   spike_count
`endif
);

    izh_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    fx_t              i_lat_q;
    logic [15:0]      timestep_q;
    logic             spike_valid_q;
    logic [IDX_W-1:0] spike_idx_q;

    logic             cfg_acc;
    logic             start_acc;
    logic             last_idx;
    logic             spike_hs;
    logic             advance;

    logic             bank_we;
    logic             bank_we_param;
    logic [IDX_W-1:0] bank_w_idx;
    neuron_t          bank_w_data;
    neuron_t          bank_r_data;

    // A config write in the same cycle as start takes priority.
    assign cfg_acc   = (state_q == IDLE) && cfg_we;
    assign start_acc = (state_q == IDLE) && start && !cfg_we;
    assign last_idx  = (idx_q == IDX_W'(N_NEURONS - 1));
    assign spike_hs  = spike_valid_q && spike_ready;
    assign advance   = ((state_q == CAPTURE) && !dp_fired) ||
                       ((state_q == EMIT) && spike_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_acc) state_d = FETCH;
            FETCH:   if (i_valid) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                if (dp_fired)      state_d = EMIT;
                else if (last_idx) state_d = DONE;
                else               state_d = FETCH;
            end
            EMIT: begin
                if (spike_hs) state_d = last_idx ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE) && (state_q != DONE);
        done          = (state_q == DONE);
        i_req         = (state_q == FETCH);
        bank_we       = cfg_acc || (state_q == CAPTURE);
        bank_we_param = cfg_acc;
        bank_w_idx    = cfg_acc ? cfg_idx : idx_q;
        bank_w_data   = '{a: cfg_a, b: cfg_b, c: cfg_c, d: cfg_d, v: cfg_c, u: U_RST};
        if (!cfg_acc) begin
            bank_w_data.v = dp_v_prime;
            bank_w_data.u = dp_u_prime;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            i_lat_q       <= '0;
            timestep_q    <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
        end else begin
            if (start_acc) begin
                idx_q <= '0;
            end else if (advance && !last_idx) begin
                idx_q <= idx_q + 1'b1;
            end
            if ((state_q == FETCH) && i_valid) begin
                i_lat_q <= i_data;
            end
            if ((state_q == CAPTURE) && dp_fired) begin
                spike_valid_q <= 1'b1;
                spike_idx_q   <= idx_q;
            end else if ((state_q == EMIT) && spike_hs) begin
                spike_valid_q <= 1'b0;
            end
            if (state_q == DONE) begin
                timestep_q <= timestep_q + 16'd1;
            end
        end
    end

`ifdef IZH_SPIKE_COUNT_EN
    logic [IDX_W:0] spike_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count_q <= '0;
        end else if (start_acc) begin
            spike_count_q <= '0;
        end else if (spike_hs) begin
            spike_count_q <= spike_count_q + 1'b1;
        end
    end

    assign spike_count = spike_count_q;
`endif

    izh_state_bank #(
        .N_NEURONS (N_NEURONS),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bank_we),
        .we_param (bank_we_param),
        .w_idx    (bank_w_idx),
        .w_data   (bank_w_data),
        .r_idx    (idx_q),
        .r_data   (bank_r_data)
    );

    assign dp_a        = bank_r_data.a;
    assign dp_b        = bank_r_data.b;
    assign dp_c        = bank_r_data.c;
    assign dp_d        = bank_r_data.d;
    assign dp_v        = bank_r_data.v;
    assign dp_u        = bank_r_data.u;
    assign dp_i        = i_lat_q;
    assign i_idx       = idx_q;
    assign timestep    = timestep_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;

endmodule

// File: tb/tb_izh_scheduler.sv
// Scoreboard bench for izh_scheduler with a stub registered datapath.
`timescale 1ns/1ps
module tb_izh_scheduler;
    import izh_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    localparam fx_t I_FIRE  = 17'b0_0000_1010_0000_0000;
    localparam fx_t I_SMALL = 17'b0_0000_0010_1000_0000;
    localparam fx_t A3 = 17'b0_0000_0000_0000_1010;
    localparam fx_t B3 = 17'b0_0000_0000_0100_0000;
    localparam fx_t C3 = 17'b1_0011_0010_0000_0000;
    localparam fx_t D3 = 17'b0_0000_0110_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, busy, done, cfg_we, i_req, i_valid;
    logic [15:0]    timestep;
    logic [IW-1:0]  cfg_idx, i_idx, spike_idx;
    fx_t            cfg_a, cfg_b, cfg_c, cfg_d, i_data;
    fx_t            dp_a, dp_b, dp_c, dp_d, dp_v, dp_u, dp_i;
    fx_t            dp_v_prime, dp_u_prime;
    logic           dp_fired, spike_valid, spike_ready;
`ifdef IZH_SPIKE_COUNT_EN
    logic [IW:0]    spike_count;
`endif

    izh_scheduler #(.N_NEURONS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .timestep(timestep), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c), .cfg_d(cfg_d),
        .i_req(i_req), .i_idx(i_idx), .i_valid(i_valid), .i_data(i_data),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
        .dp_v_prime(dp_v_prime), .dp_u_prime(dp_u_prime), .dp_fired(dp_fired),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready)
`ifdef IZH_SPIKE_COUNT_EN
        , .spike_count(spike_count)
`endif
    );

    typedef struct {
        logic [IW-1:0] idx;
        fx_t v, u, i, a, b, c, d;
    } exp_t;

    typedef struct {
        int          lat;
        logic [15:0] ts;
        int          nsp;
    } done_t;

    exp_t          exp_q[$];
    logic [IW-1:0] spk_q[$];
    done_t         done_q[$];

    int checks   = 0;
    int failures = 0;

    fx_t ma[N], mb[N], mc[N], md[N], mv[N], mu[N];
    fx_t cur[N];
    int  dly[N];
    int  hold;
    int  stub_mode;
    logic [15:0] exp_ts;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    // Stub datapath: mode 0 echoes v/u; mode 1 fires when i==I_FIRE (v<-c, u<-d),
    // otherwise stores i into v.
    task automatic stub_dp(input int mode, input fx_t v, u, c, d, i,
                           output fx_t nv, output fx_t nu, output logic f);
        nv = v;
        nu = u;
        f  = 1'b0;
        if (mode == 1) begin
            if (i == I_FIRE) begin
                f  = 1'b1;
                nv = c;
                nu = d;
            end else begin
                nv = i;
            end
        end
    endtask

    always @(posedge clk) begin : stub
        fx_t  nv, nu;
        logic f;
        stub_dp(stub_mode, dp_v, dp_u, dp_c, dp_d, dp_i, nv, nu, f);
        dp_v_prime <= nv;
        dp_u_prime <= nu;
        dp_fired   <= f;
    end

    // Current source: answers i_req after dly[i_idx] extra cycles.
    initial begin : current_src
        int fcnt;
        fcnt    = 0;
        i_valid = 1'b0;
        i_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !i_req) begin
                i_valid = 1'b0;
                fcnt    = 0;
            end else if (fcnt >= dly[i_idx]) begin
                i_valid = 1'b1;
                i_data  = cur[i_idx];
            end else begin
                i_valid = 1'b0;
                fcnt++;
            end
        end
    end

    // Spike consumer: stalls each spike for 'hold' cycles.
    initial begin : spike_sink
        int hcnt;
        hcnt        = 0;
        spike_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !spike_valid) begin
                spike_ready = 1'b0;
                hcnt        = 0;
            end else if (hcnt < hold) begin
                spike_ready = 1'b0;
                hcnt++;
            end else begin
                spike_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t          rec;
        done_t         dr;
        logic [IW-1:0] sid;
        logic          pend, ts_pend;
        logic [15:0]   ts_exp;
        int            run_cnt;
        pend    = 1'b0;
        ts_pend = 1'b0;
        ts_exp  = '0;
        run_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend    = 1'b0;
                ts_pend = 1'b0;
                run_cnt = 0;
                continue;
            end
            if (ts_pend) begin
                chk("timestep", timestep, ts_exp);
                ts_pend = 1'b0;
            end
            if (pend) begin
                chk($sformatf("dp_v[%0d]", rec.idx), dp_v, rec.v);
                chk($sformatf("dp_u[%0d]", rec.idx), dp_u, rec.u);
                chk($sformatf("dp_i[%0d]", rec.idx), dp_i, rec.i);
                chk($sformatf("dp_abcd[%0d]", rec.idx), {dp_a, dp_b, dp_c, dp_d},
                    {rec.a, rec.b, rec.c, rec.d});
                pend = 1'b0;
            end
            if (i_req && i_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_fetch", 1'b1, 1'b0);
                end else begin
                    rec = exp_q.pop_front();
                    chk("i_idx", i_idx, rec.idx);
                    pend = 1'b1;
                end
            end
            if (spike_valid) begin
                if (spk_q.size() == 0) begin
                    chk("unexpected_spike", 1'b1, 1'b0);
                end else if (spike_ready) begin
                    sid = spk_q.pop_front();
                    chk("spike_idx", spike_idx, sid);
                end else begin
                    chk("spike_idx_held", spike_idx, spk_q[0]);
                end
            end
            if (busy || done) run_cnt++;
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    dr = done_q.pop_front();
                    chk("latency", run_cnt, dr.lat);
`ifdef IZH_SPIKE_COUNT_EN
                    chk("spike_count", spike_count, dr.nsp);
`endif
                    ts_exp  = dr.ts;
                    ts_pend = 1'b1;
                end
                run_cnt = 0;
            end
        end
    end

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            ma[n] = A_DEF; mb[n] = B_DEF; mc[n] = V_RST; md[n] = D_DEF;
            mv[n] = V_RST; mu[n] = U_RST;
            cur[n] = '0;   dly[n] = 0;
        end
        hold   = 0;
        exp_ts = '0;
    endtask

    task automatic prepare_ts(input int mode, input int lat);
        exp_t rec;
        fx_t  nv, nu;
        logic f;
        int   nsp;
        nsp       = 0;
        stub_mode = mode;
        for (int n = 0; n < N; n++) begin
            rec.idx = IW'(n);
            rec.v = mv[n]; rec.u = mu[n]; rec.i = cur[n];
            rec.a = ma[n]; rec.b = mb[n]; rec.c = mc[n]; rec.d = md[n];
            exp_q.push_back(rec);
            stub_dp(mode, mv[n], mu[n], mc[n], md[n], cur[n], nv, nu, f);
            mv[n] = nv;
            mu[n] = nu;
            if (f) begin
                spk_q.push_back(IW'(n));
                nsp++;
            end
        end
        exp_ts = exp_ts + 16'd1;
        done_q.push_back('{lat: lat, ts: exp_ts, nsp: nsp});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_ts(input int mode, input int lat, input logic poke);
        prepare_ts(mode, lat);
        pulse_start();
        if (poke) begin
            repeat (10) @(negedge clk);
            start   = 1'b1;
            cfg_we  = 1'b1;
            cfg_idx = 4'd2;
            cfg_a = 17'h1FFFF; cfg_b = 17'h1FFFF; cfg_c = 17'h1FFFF; cfg_d = 17'h1FFFF;
            @(negedge clk);
            start  = 1'b0;
            cfg_we = 1'b0;
        end
        for (int k = 0; k < 400 && !done; k++) @(negedge clk);
        chk("done_seen", done, 1'b1);
        @(negedge clk);
        chk("idle_after_done", busy, 1'b0);
        @(negedge clk);
        chk("no_queued_start", busy, 1'b0);
    endtask

    initial begin : main
        logic hit;
        rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_a = '0; cfg_b = '0; cfg_c = '0; cfg_d = '0;
        stub_mode = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_timestep", timestep, 16'd0);
        chk("rst_i_req", i_req, 1'b0);
        chk("rst_spike_valid", spike_valid, 1'b0);
        chk("rst_spike_idx", spike_idx, 4'd0);
        rst_n = 1'b1;

        // Echo pass reads back reset defaults for every neuron.
        run_ts(0, 49, 1'b0);

        // Config write and start together: config wins, start is dropped.
        @(negedge clk);
        cfg_we = 1'b1; start = 1'b1; cfg_idx = 4'd3;
        cfg_a = A3; cfg_b = B3; cfg_c = C3; cfg_d = D3;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        chk("cfg_beats_start", busy, 1'b0);
        ma[3] = A3; mb[3] = B3; mc[3] = C3; md[3] = D3; mv[3] = C3; mu[3] = U_RST;

        cur[3] = I_SMALL;
        run_ts(1, 49, 1'b1);

        cur[3] = I_FIRE; cur[9] = I_FIRE; dly[7] = 5; hold = 4;
        run_ts(1, 49 + 2 * (1 + 4) + 5, 1'b0);

        cur[3] = '0; cur[9] = '0; dly[7] = 0; hold = 0;
        run_ts(1, 49, 1'b0);

        // Async reset while neuron 5 is in CAPTURE.
        stub_mode = 0;
        for (int n = 0; n < N; n++) cur[n] = I_SMALL;
        prepare_ts(0, 49);
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (i_req && i_valid && i_idx == 4'd5) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reached_idx5", hit, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_i_req", i_req, 1'b0);
        chk("abort_timestep", timestep, 16'd0);
        chk("abort_spike_idx", spike_idx, 4'd0);
        chk("abort_done", done, 1'b0);
        exp_q.delete();
        spk_q.delete();
        done_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_ts(0, 49, 1'b0);

        // Timestep wrap from 0xFFFF.
        @(negedge clk);
        force dut.timestep_q = 16'hFFFF;
        @(negedge clk);
        release dut.timestep_q;
        @(negedge clk);
        chk("ts_preload", timestep, 16'hFFFF);
        exp_ts = 16'hFFFF;
        run_ts(0, 49, 1'b0);

        chk("queues_drained", exp_q.size() + spk_q.size() + done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
